// File: rtl/fir_filter_2d_param_if.sv
// Beat interface between the DMA controller and the 2D FIR core.
//   input_data  : beat payload (pixels or a coefficient word), lane 0 in the MSBs
//   valid_dmac  : beat qualifier
//   tc_set      : together with valid_dmac, marks the beat as a coefficient
//   output_data : filtered pixels, lane 0 in the MSBs
//   valid_core  : one-cycle pulse when output_data is updated
//   coef_loaded : a complete coefficient set is present
// master = DMA side, slave = filter core.
interface fir_filter_2d_param_if #(
  parameter int LANES = 10,
  parameter int CH    = 3,
  parameter int DW    = 8
);
  logic [LANES*CH*DW-1:0] input_data;
  logic                   valid_dmac;
  logic                   tc_set;
  logic [LANES*CH*DW-1:0] output_data;
  logic                   valid_core;
  logic                   coef_loaded;

  modport master (
    output input_data, valid_dmac, tc_set,
    input  output_data, valid_core, coef_loaded
  );

  modport slave (
    input  input_data, valid_dmac, tc_set,
    output output_data, valid_core, coef_loaded
  );
endinterface

// File: rtl/fir_filter_2d_param.sv
// K x K, multi-lane, multi-channel 2D FIR core.
// Coefficient beats (valid_dmac & tc_set) load one tap (CH signed bytes, R high)
// per beat; after NT taps coef_loaded rises. Data beats (valid_dmac & ~tc_set)
// carry one window element for LANES pixels, row-major. After the NT-th element
// each lane/channel sum is arithmetically shifted by SHIFT, clamped to
// [0, 2^DW-1], registered on output_data, and valid_core pulses for one cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fir_filter_2d_param_if
module fir_filter_2d_param #(
  parameter int LANES = 10,
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int K     = 3,
  parameter int SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fir_filter_2d_param_if.slave   bus
);
  localparam int NT   = K * K;
  localparam int TW   = (NT > 1) ? $clog2(NT) : 1;
  localparam int AW   = DW + CW + $clog2(NT) + 1;
  localparam int PW   = DW + CW + 1;
  localparam int NACC = LANES * CH;
  localparam int BW   = NACC * DW;
  localparam logic [TW-1:0]        LAST_TAP = TW'(NT - 1);
  localparam logic signed [AW-1:0] SAT_MAX  = AW'((1 << DW) - 1);

  function automatic logic [DW-1:0] shift_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> SHIFT;
    if (s[AW-1]) return '0;
    if (s > SAT_MAX) return '1;
    return s[DW-1:0];
  endfunction

  logic signed [CW-1:0] coef_q [NT][CH];
  logic signed [CW-1:0] coef_d [NT][CH];
  logic [TW-1:0]        tap_cnt_q, tap_cnt_d;
  logic [TW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 coef_loaded_q, coef_loaded_d;
  logic                 valid_core_q, valid_core_d;
  logic signed [AW-1:0] acc_q [NACC];
  logic signed [AW-1:0] acc_d [NACC];
  logic [BW-1:0]        out_q, out_d;

  // Index i walks the payload from the MSB: i = lane*CH + channel.
  logic signed [PW-1:0] prod_w [NACC];
  logic signed [AW-1:0] sum_w  [NACC];

  always_comb begin
    for (int i = 0; i < NACC; i++) begin
      // Pixel is zero-extended so an 8-bit 0xFF stays +255 in the signed product.
      prod_w[i] = $signed({1'b0, bus.input_data[BW-1-i*DW -: DW]}) * coef_q[beat_cnt_q][i % CH];
      sum_w[i]  = acc_q[i] + AW'(prod_w[i]);
    end
  end

  always_comb begin
    coef_d        = coef_q;
    tap_cnt_d     = tap_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    coef_loaded_d = coef_loaded_q;
    acc_d         = acc_q;
    out_d         = out_q;
    valid_core_d  = 1'b0;

    if (bus.valid_dmac && bus.tc_set) begin
      for (int c = 0; c < CH; c++) begin
        coef_d[tap_cnt_q][c] = bus.input_data[CH*CW-1-c*CW -: CW];
      end
      // Any coefficient beat other than the last of a set leaves the set incomplete,
      // so the first beat after a complete set drops coef_loaded.
      if (tap_cnt_q == LAST_TAP) begin
        tap_cnt_d     = '0;
        coef_loaded_d = 1'b1;
      end else begin
        tap_cnt_d     = tap_cnt_q + TW'(1);
        coef_loaded_d = 1'b0;
      end
      // A coefficient beat aborts any partial data burst.
      beat_cnt_d = '0;
      for (int i = 0; i < NACC; i++) acc_d[i] = '0;
    end else if (bus.valid_dmac && coef_loaded_q) begin
      if (beat_cnt_q == LAST_TAP) begin
        for (int i = 0; i < NACC; i++) begin
          out_d[BW-1-i*DW -: DW] = shift_sat(sum_w[i]);
          acc_d[i]               = '0;
        end
        valid_core_d = 1'b1;
        beat_cnt_d   = '0;
      end else begin
        acc_d      = sum_w;
        beat_cnt_d = beat_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) begin
        for (int c = 0; c < CH; c++) coef_q[t][c] <= '0;
      end
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
      tap_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      coef_loaded_q <= 1'b0;
      valid_core_q  <= 1'b0;
      out_q         <= '0;
    end else begin
      coef_q        <= coef_d;
      acc_q         <= acc_d;
      tap_cnt_q     <= tap_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      coef_loaded_q <= coef_loaded_d;
      valid_core_q  <= valid_core_d;
      out_q         <= out_d;
    end
  end

  assign bus.output_data = out_q;
  assign bus.valid_core  = valid_core_q;
  assign bus.coef_loaded = coef_loaded_q;
endmodule

// File: tb/tb_fir_filter_2d_param.sv
// Bench for fir_filter_2d_param: two instances (SHIFT=0 and SHIFT=3) share one
// stimulus stream; a behavioural window/convolution model predicts every output.
module tb_fir_filter_2d_param;
  localparam int LANES = 10;
  localparam int BW    = LANES * 24;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] in_data;
  logic          vld;
  logic          tc;

  int n_chk;
  int n_fail;

  fir_filter_2d_param_if #(.LANES(LANES), .CH(3), .DW(8)) if0 ();
  fir_filter_2d_param_if #(.LANES(LANES), .CH(3), .DW(8)) if3 ();

  assign if0.input_data = in_data;
  assign if0.valid_dmac = vld;
  assign if0.tc_set     = tc;
  assign if3.input_data = in_data;
  assign if3.valid_dmac = vld;
  assign if3.tc_set     = tc;

  fir_filter_2d_param #(.LANES(LANES), .CH(3), .DW(8), .CW(8), .K(3), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  fir_filter_2d_param #(.LANES(LANES), .CH(3), .DW(8), .CW(8), .K(3), .SHIFT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_coef [9][3];
  int            m_tap;
  int            m_cnt;
  bit            m_loaded;
  logic [23:0]   m_win [9][LANES];
  logic [BW-1:0] e_out0, e_out3;
  logic          e_vld, e_loaded;

  function automatic logic [7:0] sat8(input int v);
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 9; t++) for (int c = 0; c < 3; c++) m_coef[t][c] = 0;
      m_tap = 0; m_cnt = 0; m_loaded = 0;
      e_out0 = '0; e_out3 = '0; e_vld = 0; e_loaded = 0;
    end else begin
      e_vld = 0;
      if (vld && tc) begin
        for (int c = 0; c < 3; c++) m_coef[m_tap][c] = int'($signed(in_data[23-8*c -: 8]));
        m_tap++;
        m_loaded = 0;
        if (m_tap == 9) begin m_tap = 0; m_loaded = 1; end
        m_cnt = 0;
      end else if (vld && m_loaded) begin
        for (int l = 0; l < LANES; l++) m_win[m_cnt][l] = in_data[BW-1-24*l -: 24];
        if (m_cnt == 8) begin
          for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < 3; c++) begin
              int s;
              s = 0;
              for (int t = 0; t < 9; t++) s += int'(m_win[t][l][23-8*c -: 8]) * m_coef[t][c];
              e_out0[BW-1-24*l-8*c -: 8] = sat8(s);
              e_out3[BW-1-24*l-8*c -: 8] = sat8(s >>> 3);
            end
          end
          e_vld = 1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      e_loaded = m_loaded;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("out_s0", if0.output_data, e_out0);
    chk("out_s3", if3.output_data, e_out3);
    chk("valid_s0", BW'(if0.valid_core), BW'(e_vld));
    chk("valid_s3", BW'(if3.valid_core), BW'(e_vld));
    chk("loaded_s0", BW'(if0.coef_loaded), BW'(e_loaded));
    chk("loaded_s3", BW'(if3.coef_loaded), BW'(e_loaded));
  end

  // ---------------- stimulus helpers ----------------
  logic [23:0]   cset [9];
  logic [BW-1:0] wb   [9];

  function automatic logic [BW-1:0] rnd_bus();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r[BW-1:0];
  endfunction

  task automatic beat(input bit v, input bit t, input logic [BW-1:0] d);
    vld = v; tc = t; in_data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom_range(0, 1)), rnd_bus());
  endtask

  task automatic coef_beat(input logic [23:0] c);
    logic [BW-1:0] d;
    d = rnd_bus();
    d[23:0] = c;
    beat(1'b1, 1'b1, d);
  endtask

  task automatic load_set();
    for (int t = 0; t < 9; t++) coef_beat(cset[t]);
  endtask

  // pause_after < 0 means no pause; otherwise idle pause_len cycles after that beat index.
  task automatic burst(input int pause_after, input int pause_len);
    for (int t = 0; t < 9; t++) begin
      beat(1'b1, 1'b0, wb[t]);
      if (t == pause_after) idle(pause_len);
    end
    vld = 1'b0; tc = 1'b0;
  endtask

  task automatic fill_flat(input logic [23:0] p);
    for (int t = 0; t < 9; t++) wb[t] = {LANES{p}};
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; vld = 1'b0; tc = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", if0.output_data, '0);
    chk("reset_loaded", BW'(if0.coef_loaded), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Data before any coefficients is dropped.
    for (int t = 0; t < 9; t++) wb[t] = rnd_bus();
    burst(-1, 0);
    idle(2);

    // Identity kernel: centre tap 1 on every channel.
    for (int t = 0; t < 9; t++) cset[t] = 24'h000000;
    cset[4] = 24'h010101;
    load_set();
    for (int t = 0; t < 9; t++) wb[t] = rnd_bus();
    wb[4] = {LANES{24'h123456}};
    burst(-1, 0);
    chk("identity", if0.output_data, {LANES{24'h123456}});
    chk("identity_model", e_out0, {LANES{24'h123456}});
    chk("identity_s3", if3.output_data, {LANES{24'h02060A}});
    idle(4);

    // Emboss kernel, coefficient sum 0.
    cset[0] = 24'h020202; cset[1] = 24'h010101; cset[2] = 24'h000000;
    cset[3] = 24'h010101; cset[4] = 24'h000000; cset[5] = 24'hFFFFFF;
    cset[6] = 24'h000000; cset[7] = 24'hFFFFFF; cset[8] = 24'hFEFEFE;
    load_set();
    fill_flat(24'h101010);
    burst(-1, 0);
    chk("emboss_flat", if0.output_data, '0);
    fill_flat(24'h000000);
    wb[4] = {LANES{24'h404040}};
    burst(-1, 0);
    chk("emboss_centre", if0.output_data, '0);
    // Edge-like window: top row bright gives positive output.
    fill_flat(24'h000000);
    for (int t = 0; t < 3; t++) wb[t] = {LANES{24'h102030}};
    burst(-1, 0);
    chk("emboss_edge_model", e_out0, {LANES{24'h306090}});
    idle(4);

    // Saturation high and low.
    for (int t = 0; t < 9; t++) cset[t] = 24'h7F7F7F;
    load_set();
    fill_flat(24'hFFFFFF);
    burst(-1, 0);
    chk("sat_high", if0.output_data, {LANES{24'hFFFFFF}});
    chk("sat_high_s3", if3.output_data, {LANES{24'hFFFFFF}});
    for (int t = 0; t < 9; t++) cset[t] = 24'h808080;
    load_set();
    burst(-1, 0);
    chk("sat_low", if0.output_data, '0);
    chk("sat_low_model", e_out0, '0);

    // Shift: 9*8 = 72.
    for (int t = 0; t < 9; t++) cset[t] = 24'h010101;
    load_set();
    fill_flat(24'h080808);
    burst(-1, 0);
    chk("shift3", if3.output_data, {LANES{24'h090909}});
    chk("shift3_model", e_out3, {LANES{24'h090909}});
    chk("shift0", if0.output_data, {LANES{24'h484848}});

    // Pause after beat 4 gives the same result; then back-to-back bursts.
    for (int t = 0; t < 9; t++) cset[t] = 24'($urandom);
    load_set();
    for (int t = 0; t < 9; t++) wb[t] = rnd_bus();
    burst(-1, 0);
    begin
      logic [BW-1:0] ref0;
      ref0 = e_out0;
      idle(3);
      burst(4, 5);
      chk("pause_same", if0.output_data, ref0);
    end
    burst(-1, 0);
    burst(-1, 0);
    idle(4);

    // Abort: coefficient beat in place of data beat 6.
    for (int t = 0; t < 6; t++) beat(1'b1, 1'b0, wb[t]);
    for (int t = 0; t < 9; t++) cset[t] = 24'($urandom);
    coef_beat(cset[0]);
    chk("abort_loaded", BW'(if0.coef_loaded), '0);
    chk("abort_valid", BW'(if0.valid_core), '0);
    burst(-1, 0);
    for (int t = 1; t < 9; t++) coef_beat(cset[t]);
    burst(-1, 0);
    idle(2);

    // Asynchronous reset mid-burst.
    for (int t = 0; t < 4; t++) beat(1'b1, 1'b0, wb[t]);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", if0.output_data, '0);
    chk("async_valid", BW'(if0.valid_core), '0);
    chk("async_loaded", BW'(if0.coef_loaded), '0);
    @(negedge clk);
    rst_n = 1'b1;
    burst(-1, 0);
    chk("post_reset_drop", if0.output_data, '0);
    load_set();
    burst(-1, 0);

    // Randomised rounds.
    for (int r = 0; r < 20; r++) begin
      for (int t = 0; t < 9; t++) begin
        case ($urandom_range(0, 3))
          0: cset[t] = 24'h7F807F;
          1: cset[t] = 24'h000000;
          default: cset[t] = 24'($urandom);
        endcase
      end
      load_set();
      for (int b = 0; b < 3; b++) begin
        for (int t = 0; t < 9; t++) begin
          beat(1'b1, 1'b0, rnd_bus());
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
      end
      idle($urandom_range(0, 4));
    end

    vld = 1'b0; tc = 1'b0;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_filter_2d_param.md
# fir_filter_2d_param

Parametrised successor to the fixed 3x3 RGB 2D FIR core: a K×K, multi-lane, multi-channel filter with per-channel signed coefficients, an arithmetic post-shift and unsigned saturation. The block sits behind the DMA controller (`valid_dmac` / `tc_set` handshake). It consumes one window element for LANES pixels per beat and emits one LANES-wide filtered beat per completed K×K burst.

## Interface
- LANES, 10, pixels carried per beat
- CH, 3, channels per pixel (R,G,B; R in the most significant byte)
- DW, 8, unsigned pixel channel width
- CW, 8, signed coefficient width per channel
- K, 3, kernel side; taps NT = K*K
- SHIFT, 0, arithmetic right shift applied to each sum before saturation
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- input_data  in  LANES*CH*DW  beat payload; lane 0 in the MSBs
- valid_dmac  in  1  beat qualifier
- tc_set  in  1  with valid_dmac, beat is a coefficient
- output_data  out  LANES*CH*DW  filtered pixels; lane 0 in the MSBs
- valid_core  out  1  one-cycle pulse, output_data updated
- coef_loaded  out  1  full NT-coefficient set present

## Operation
- One clock; rst_n is asynchronous and active-low.
- On reset: coefficients = 0, tap_cnt = 0, beat_cnt = 0, accumulators = 0, output_data = 0, valid_core = 0, coef_loaded = 0.
- Coefficient beat: valid_dmac=1 and tc_set=1.
  - coef[tap_cnt] <= input_data[CH*CW-1:0], with the R byte high.
  - tap_cnt increments; at NT-1 it wraps to 0 and coef_loaded <= 1.
  - The first coefficient beat after coef_loaded=1 clears coef_loaded and starts a new set.
  - A coefficient beat also clears beat_cnt and the accumulators, aborting any partial data burst with no output.
- Data beat: valid_dmac=1, tc_set=0, coef_loaded=1.
  - Beat beat_cnt carries window element t = beat_cnt, row-major (t=0 top-left, t=NT-1 bottom-right).
  - Per lane and per channel: acc += zext(pixel) * sext(coef[t][ch]).
- Data beats with coef_loaded=0 are dropped: no accumulation, counter unchanged.
- valid_dmac=0 mid-burst pauses the burst; beat_cnt and acc hold, and the burst resumes on the next beat.
- Last data beat (beat_cnt = NT-1):
  - result = (acc + product) >>> SHIFT, saturated to [0, 2^DW-1]: negative gives 0, above the maximum gives 2^DW-1.
  - result is registered into output_data and valid_core pulses.
  - acc is cleared and beat_cnt returns to 0.
- Accumulator width AW = DW + CW + clog2(NT) + 1, signed. Never overflows.
- output_data holds until the next completed burst.

## Timing
- Latency: output_data and valid_core change at the same rising edge that samples the last data beat. valid_core stays high exactly one cycle.
- Back-to-back bursts (valid_dmac continuously high for 2·NT beats) produce two pulses NT cycles apart. No bubble is required.
- tc_set with valid_dmac=0 is ignored.
- Reset asserted mid-burst: all state clears immediately. Coefficients must be reloaded before data is accepted.
- Legacy DMA pacing (NT beats high, 4 cycles low, output sampled 2 cycles after valid_dmac falls) sees a stable output_data.

## Test plan
- Identity: coef[4]=0x010101, others 0, K=3, SHIFT=0. Window of any pixels with centre 0x123456 per lane -> output lane = 0x123456, valid_core pulses once per 9 beats.
- Emboss taps 02,01,00,01,00,FF,00,FF,FE (all channels), flat window 0x101010 -> output 0x000000 (coefficient sum is 0). Centre-only 0x40 with all other elements 0 -> 0x000000.
- Saturation: all coefs 0x7F, all pixels 0xFF -> 0xFFFFFF. All coefs 0x80, all pixels 0xFF -> 0x000000.
- Shift: SHIFT=3, all coefs 0x01, all pixels 0x08 -> 9·8 >> 3 = 0x090909.
- Pause/abort:
  - valid_dmac dropped for 5 cycles after beat 4 -> same result as the unpaused burst.
  - A coefficient beat at data beat 6 -> no valid_core, coef_loaded=0. Subsequent data beats are dropped until 9 coefficient beats complete.
- Reset: rst_n low for 1 cycle mid-burst -> output_data=0, valid_core=0, coef_loaded=0 asynchronously. Data before a reload is dropped.
